// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared MIPS encodings used by the main control, the ALU
//                control and the ALU: opcode constants (*_op), R-type funct
//                constants (*_f) and 4-bit ALU operation codes (ALU_*).
//  Revision    : 1.0  initial release
// ============================================================================
package mips_pkg;

    // Opcode field, instruction bits [31:26]
    localparam logic [5:0] R_TYPE_op = 6'b000000;
    localparam logic [5:0] J_op      = 6'b000010;
    localparam logic [5:0] BEQ_op    = 6'b000100;
    localparam logic [5:0] ADDI_op   = 6'b001000;
    localparam logic [5:0] ADDIU_op  = 6'b001001;
    localparam logic [5:0] SLTI_op   = 6'b001010;
    localparam logic [5:0] ANDI_op   = 6'b001100;
    localparam logic [5:0] ORI_op    = 6'b001101;
    localparam logic [5:0] LW_op     = 6'b100011;
    localparam logic [5:0] SW_op     = 6'b101011;

    // Funct field, instruction bits [5:0], meaningful only for R_TYPE_op
    localparam logic [5:0] ADD_f     = 6'b100000;
    localparam logic [5:0] ADDU_f    = 6'b100001;
    localparam logic [5:0] SUB_f     = 6'b100010;
    localparam logic [5:0] SUBU_f    = 6'b100011;
    localparam logic [5:0] AND_f     = 6'b100100;
    localparam logic [5:0] OR_f      = 6'b100101;
    localparam logic [5:0] XOR_f     = 6'b100110;
    localparam logic [5:0] NOR_f     = 6'b100111;
    localparam logic [5:0] SLT_f     = 6'b101010;
    localparam logic [5:0] SLTU_f    = 6'b101011;

    // ALU operation codes
    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_XOR   = 4'b0011;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_SLT   = 4'b0111;
    localparam logic [3:0] ALU_SLTU  = 4'b1000;
    localparam logic [3:0] ALU_NOR   = 4'b1100;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/alu_control_decode.sv
`default_nettype none
// ============================================================================
//  Module      : alu_control_decode
//  Description : Combinational opcode / funct decode to the next ALU
//                operation code and an illegal-instruction flag.
//  Ports       : i_op       [5:0]  instruction opcode
//                i_func     [5:0]  R-type funct, ignored for other opcodes
//                o_alu_ctrl [3:0]  decoded ALU operation
//                o_illegal         1 = unsupported opcode or funct
//  Revision    : 1.0  initial release
// ============================================================================
module alu_control_decode
    import mips_pkg::*;
(
    input  logic [5:0] i_op,
    input  logic [5:0] i_func,
    output logic [3:0] o_alu_ctrl,
    output logic       o_illegal
);

    // Unsupported encodings fall back to ADD so the ALU sees a benign op.
    always_comb begin
        o_alu_ctrl = ALU_ADD;
        o_illegal  = 1'b0;
        unique case (i_op)
            ADDI_op, ADDIU_op, LW_op, SW_op: o_alu_ctrl = ALU_ADD;
            J_op:                            o_alu_ctrl = ALU_ADD; // result unused
            BEQ_op:                          o_alu_ctrl = ALU_SUB;
            ANDI_op:                         o_alu_ctrl = ALU_AND;
            ORI_op:                          o_alu_ctrl = ALU_OR;
            SLTI_op:                         o_alu_ctrl = ALU_SLT;
            R_TYPE_op: begin
                unique case (i_func)
                    ADD_f, ADDU_f: o_alu_ctrl = ALU_ADD;
                    SUB_f, SUBU_f: o_alu_ctrl = ALU_SUB;
                    AND_f:         o_alu_ctrl = ALU_AND;
                    OR_f:          o_alu_ctrl = ALU_OR;
                    XOR_f:         o_alu_ctrl = ALU_XOR;
                    NOR_f:         o_alu_ctrl = ALU_NOR;
                    SLT_f:         o_alu_ctrl = ALU_SLT;
                    SLTU_f:        o_alu_ctrl = ALU_SLTU;
                    default: begin
                        o_alu_ctrl = ALU_ADD;
                        o_illegal  = 1'b1;
                    end
                endcase
            end
            default: begin
                o_alu_ctrl = ALU_ADD;
                o_illegal  = 1'b1;
            end
        endcase
    end

endmodule : alu_control_decode
`default_nettype wire

// File: rtl/alu_control.sv
`default_nettype none
// ============================================================================
//  Module      : alu_control
//  Description : Registered MIPS ALU control. Decodes opcode/funct into the
//                4-bit ALU operation with one cycle of latency.
//  Ports       : i_clk               system clock, rising edge
//                i_rst_n             synchronous active-low reset
//                i_op         [5:0]  instruction opcode
//                i_func       [5:0]  R-type funct field
//                o_aluControl [3:0]  registered ALU operation code
//                o_illegal           registered unsupported-instruction flag
//  Revision    : 1.0  initial release
// ============================================================================
module alu_control
    import mips_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [5:0] i_op,
    input  logic [5:0] i_func,
    output logic [3:0] o_aluControl,
    output logic       o_illegal
);

    logic [3:0] w_alu_ctrl;
    logic       w_illegal;
    logic [3:0] r_alu_ctrl;
    logic       r_illegal;

    alu_control_decode u_decode (
        .i_op       (i_op),
        .i_func     (i_func),
        .o_alu_ctrl (w_alu_ctrl),
        .o_illegal  (w_illegal)
    );

    // Reset wins over the decode, so a decode pending at a reset edge is lost.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_alu_ctrl <= ALU_ADD;
            r_illegal  <= 1'b0;
        end else begin
            r_alu_ctrl <= w_alu_ctrl;
            r_illegal  <= w_illegal;
        end
    end

    assign o_aluControl = r_alu_ctrl;
    assign o_illegal    = r_illegal;

endmodule : alu_control
`default_nettype wire

// File: tb/tb_alu_control.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_control
//  Description : Self-checking bench for alu_control. A table-driven model
//                built from the instruction lists predicts each registered
//                output; directed sweeps are followed by random stimulus.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] op;
    logic [5:0] func;
    logic [3:0] alu;
    logic       illegal;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Model tables: opcode/funct -> ALU code; absent key means illegal.
    logic [3:0] op_map   [logic [5:0]];
    logic [3:0] func_map [logic [5:0]];
    logic [5:0] legal_ops [$];

    logic [3:0] exp_alu_q;
    logic       exp_ill_q;
    bit         have_prev = 0;

    alu_control dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_op         (op),
        .i_func       (func),
        .o_aluControl (alu),
        .o_illegal    (illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [5:0] m_op, input logic [5:0] m_f,
                                  input logic m_rst_n,
                                  output logic [3:0] m_alu, output logic m_ill);
        m_alu = 4'b0010;
        m_ill = 1'b0;
        if (!m_rst_n) return;
        if (m_op == 6'b000000) begin
            if (func_map.exists(m_f)) m_alu = func_map[m_f];
            else                      m_ill = 1'b1;
        end else if (op_map.exists(m_op)) begin
            m_alu = op_map[m_op];
        end else begin
            m_ill = 1'b1;
        end
    endfunction

    // One cycle: outputs must still hold the previous result until the edge,
    // then reflect the inputs sampled at that edge.
    task automatic step(input logic [5:0] s_op, input logic [5:0] s_f,
                        input logic s_rst_n, input string tag);
        logic [3:0] e_alu;
        logic       e_ill;
        @(negedge clk);
        if (have_prev) begin
            check({tag, "_hold_alu"}, alu, exp_alu_q);
            check({tag, "_hold_ill"}, {3'b000, illegal}, {3'b000, exp_ill_q});
        end
        op    = s_op;
        func  = s_f;
        rst_n = s_rst_n;
        @(posedge clk);
        #1;
        model(s_op, s_f, s_rst_n, e_alu, e_ill);
        check({tag, "_alu"}, alu, e_alu);
        check({tag, "_ill"}, {3'b000, illegal}, {3'b000, e_ill});
        exp_alu_q = e_alu;
        exp_ill_q = e_ill;
        have_prev = 1;
    endtask

    initial begin
        op_map[6'b001000] = 4'b0010;  // ADDI
        op_map[6'b001001] = 4'b0010;  // ADDIU
        op_map[6'b100011] = 4'b0010;  // LW
        op_map[6'b101011] = 4'b0010;  // SW
        op_map[6'b000010] = 4'b0010;  // J
        op_map[6'b000100] = 4'b0110;  // BEQ
        op_map[6'b001100] = 4'b0000;  // ANDI
        op_map[6'b001101] = 4'b0001;  // ORI
        op_map[6'b001010] = 4'b0111;  // SLTI
        func_map[6'b100000] = 4'b0010;
        func_map[6'b100001] = 4'b0010;
        func_map[6'b100010] = 4'b0110;
        func_map[6'b100011] = 4'b0110;
        func_map[6'b100100] = 4'b0000;
        func_map[6'b100101] = 4'b0001;
        func_map[6'b100110] = 4'b0011;
        func_map[6'b100111] = 4'b1100;
        func_map[6'b101010] = 4'b0111;
        func_map[6'b101011] = 4'b1000;
        foreach (op_map[k]) legal_ops.push_back(k);
        legal_ops.push_back(6'b000000);

        rst_n = 1'b0;
        op    = 6'b000100;
        func  = 6'h00;

        // Reset held with BEQ, then released.
        step(6'b000100, 6'h00, 1'b0, "rst0");
        step(6'b000100, 6'h00, 1'b0, "rst1");
        step(6'b000100, 6'h00, 1'b1, "rst_rel");

        // I-type sweep with a noisy funct field.
        step(6'b001000, 6'h3F, 1'b1, "addi");
        step(6'b001001, 6'h3F, 1'b1, "addiu");
        step(6'b100011, 6'h3F, 1'b1, "lw");
        step(6'b101011, 6'h3F, 1'b1, "sw");
        step(6'b000010, 6'h3F, 1'b1, "j");
        step(6'b000100, 6'h3F, 1'b1, "beq");
        step(6'b001100, 6'h3F, 1'b1, "andi");
        step(6'b001101, 6'h3F, 1'b1, "ori");
        step(6'b001010, 6'h3F, 1'b1, "slti");

        // R-type sweep over every listed funct.
        foreach (func_map[f]) step(6'b000000, f, 1'b1, "rtype");

        // Illegal encodings, then recovery.
        step(6'b111111, 6'h20, 1'b1, "ill_op");
        step(6'b000000, 6'h00, 1'b1, "ill_func");
        step(6'b001101, 6'h00, 1'b1, "ill_recover");

        // Funct is ignored for non-R-type opcodes.
        for (int i = 0; i < 64; i++) step(6'b001100, 6'(i), 1'b1, "andi_dc");

        // Reset in the same cycle the opcode changes to SLTI.
        step(6'b001101, 6'h00, 1'b1, "pre_mid");
        step(6'b001010, 6'h00, 1'b0, "mid_rst");
        step(6'b001010, 6'h00, 1'b1, "mid_rel");

        // Random stimulus, biased toward legal opcodes, occasional reset.
        for (int i = 0; i < 400; i++) begin
            logic [5:0] r_op;
            if ($urandom_range(1) == 0)
                r_op = legal_ops[$urandom_range(legal_ops.size() - 1)];
            else
                r_op = 6'($urandom);
            step(r_op, 6'($urandom), ($urandom_range(15) != 0), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule : tb_alu_control
`default_nettype wire
